// File: rtl/dac_playback_pkg.sv
// Shared types and constants for the dac_playback waveform source.
package dac_playback_pkg;

  // Playback controller states
  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

  // Width of the sample-rate divider
  localparam int RATE_W = 16;

  // Output code while idle: zero in two's complement, mid-scale in offset binary
  localparam logic [13:0] IDLE_CODE_TC = 14'h0000;
  localparam logic [13:0] IDLE_CODE_OB = 14'h2000;

endpackage

// File: rtl/dac_playback_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port
// with one cycle of latency. A read and write to the same address in the
// same cycle returns the old contents (read-first).
module dac_playback_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic signed [DATA_W-1:0] rd_data
);

  logic signed [DATA_W-1:0] mem [2**ADDR_W];

  // Write port and registered read port; non-blocking update gives read-first
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/dac_playback.sv
// Arbitrary-waveform DAC source: CSR-loaded sample RAM played out at a
// programmable rate, one-shot or looping, into the DDR dac block.
// Optional macro DAC_PLAYBACK_OFFSET_BINARY_EN: invert the sample MSB to
// produce offset-binary codes, and idle at mid-scale instead of zero.
module dac_playback
  import dac_playback_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 14
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic signed [DATA_W-1:0] wr_data,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic [ADDR_W:0]          len,
  input  logic [RATE_W-1:0]        rate_div,
  output logic                     busy,
  output logic                     done,
  output logic                     dac_valid,
  output logic [DATA_W-1:0]        dac_data
);

`ifdef DAC_PLAYBACK_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_OB);
`else
  localparam logic [DATA_W-1:0] IDLE_CODE = DATA_W'(IDLE_CODE_TC);
`endif

  // Map a stored two's-complement sample onto the DAC code
  function automatic logic [DATA_W-1:0] to_dac(input logic signed [DATA_W-1:0] s);
`ifdef DAC_PLAYBACK_OFFSET_BINARY_EN
    return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
    return s;
`endif
  endfunction

  state_t                   state;
  state_t                   state_nxt;
  logic [ADDR_W:0]          len_q;
  logic [RATE_W-1:0]        rate_q;
  logic [RATE_W-1:0]        cnt;
  logic [ADDR_W-1:0]        addr;
  logic                     fin;
  logic                     start_ok;
  logic                     rd_en;
  logic                     rd_last;
  logic                     oneshot_last;
  logic signed [DATA_W-1:0] rd_data_p0;
  logic                     vld_p0;
  logic                     last_p0;

  // start is honoured only when fully idle, not overridden by stop, and len nonzero
  assign start_ok     = start && !stop && (state == IDLE) && !busy && (len != '0);
  assign rd_en        = (state == PLAY) && !fin && (cnt == '0);
  assign rd_last      = rd_en && ({1'b0, addr} == (len_q - (ADDR_W+1)'(1)));
  assign oneshot_last = rd_last && !loop_en;

  dac_playback_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (sys_clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_addr (addr),
    .rd_data (rd_data_p0)
  );

  // FSM state register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: stop always wins; one-shot ends when its last sample is output
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (vld_p0 && last_p0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Run control: latch parameters on start, divide the rate, step the read address
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      len_q  <= '0;
      rate_q <= '0;
      cnt    <= '0;
      addr   <= '0;
      fin    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      busy <= stop ? 1'b0 : (state == PLAY);
      if (start_ok) begin
        len_q  <= len;
        rate_q <= rate_div;
        cnt    <= '0;
        addr   <= '0;
        fin    <= 1'b0;
      end else if ((state == PLAY) && !stop) begin
        cnt <= (cnt == rate_q) ? '0 : cnt + RATE_W'(1);
        if (rd_en) begin
          if (rd_last) begin
            addr <= '0;
            fin  <= !loop_en;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
      end
    end
  end

  // ---- stage p0: RAM read in flight; stop discards it ----
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
    end else begin
      vld_p0  <= rd_en && !stop;
      last_p0 <= oneshot_last && !stop;
    end
  end

  // ---- output stage: registered DAC sample, valid strobe and done pulse ----
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      dac_valid <= 1'b0;
      done      <= 1'b0;
      dac_data  <= IDLE_CODE;
    end else if (stop) begin
      dac_valid <= 1'b0;
      done      <= 1'b0;
      dac_data  <= IDLE_CODE;
    end else begin
      dac_valid <= vld_p0;
      done      <= vld_p0 && last_p0;
      if (vld_p0) begin
        dac_data <= to_dac(rd_data_p0);
      end else if (start_ok) begin
        dac_data <= IDLE_CODE;
      end
    end
  end

endmodule

// File: tb/tb_dac_playback.sv
// Directed testbench for dac_playback: one task per scenario, hand-computed
// expectations, summary line at the end.
`timescale 1ns/1ps
module tb_dac_playback;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 14;

  logic              sys_clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              stop;
  logic              loop_en;
  logic [ADDR_W:0]   len;
  logic [15:0]       rate_div;
  logic              busy;
  logic              done;
  logic              dac_valid;
  logic [DATA_W-1:0] dac_data;

  int errors = 0;
  int checks = 0;

`ifdef DAC_PLAYBACK_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] MSB_FLIP = 14'h2000;
`else
  localparam logic [DATA_W-1:0] MSB_FLIP = 14'h0000;
`endif
  localparam logic [DATA_W-1:0] IDLE_EXP = MSB_FLIP;

  dac_playback #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .sys_clk   (sys_clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .stop      (stop),
    .loop_en   (loop_en),
    .len       (len),
    .rate_div  (rate_div),
    .busy      (busy),
    .done      (done),
    .dac_valid (dac_valid),
    .dac_data  (dac_data)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [DATA_W-1:0] code(input int v);
    logic [DATA_W-1:0] s;
    s = DATA_W'(v);
    return s ^ MSB_FLIP;
  endfunction

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = DATA_W'(d);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dac_valid); end
    checks++; if (dac_data !== IDLE_EXP) begin errors++; $display("FAIL reset_data got=%h exp=%h", dac_data, IDLE_EXP); end
  endtask

  task automatic test_oneshot();
    int vals[4] = '{100, 200, 300, 400};
    logic ev, ed, eb;
    logic [DATA_W-1:0] edat;
    for (int i = 0; i < 4; i++) wr(i, vals[i]);
    len = 11'd4; rate_div = 16'd0; loop_en = 1'b0;
    tick();
    pulse_start();
    for (int k = 1; k <= 8; k++) begin
      tick();
      ev = (k >= 2 && k <= 5);
      ed = (k == 5);
      eb = (k <= 5);
      edat = (k < 2) ? IDLE_EXP : (k <= 5) ? code(vals[k-2]) : code(400);
      checks++; if (dac_valid !== ev) begin errors++; $display("FAIL oneshot_valid k=%0d got=%b exp=%b", k, dac_valid, ev); end
      checks++; if (done !== ed) begin errors++; $display("FAIL oneshot_done k=%0d got=%b exp=%b", k, done, ed); end
      checks++; if (busy !== eb) begin errors++; $display("FAIL oneshot_busy k=%0d got=%b exp=%b", k, busy, eb); end
      checks++; if (dac_data !== edat) begin errors++; $display("FAIL oneshot_data k=%0d got=%h exp=%h", k, dac_data, edat); end
    end
  endtask

  task automatic test_loop();
    int vals[4] = '{100, 200, 300, 400};
    logic ev;
    logic [DATA_W-1:0] edat;
    len = 11'd4; rate_div = 16'd3; loop_en = 1'b1;
    tick();
    pulse_start();
    for (int k = 1; k <= 22; k++) begin
      tick();
      ev = (k >= 2) && (((k - 2) % 4) == 0);
      edat = (k < 2) ? IDLE_EXP : code(vals[((k - 2) / 4) % 4]);
      checks++; if (dac_valid !== ev) begin errors++; $display("FAIL loop_valid k=%0d got=%b exp=%b", k, dac_valid, ev); end
      checks++; if (dac_data !== edat) begin errors++; $display("FAIL loop_data k=%0d got=%h exp=%h", k, dac_data, edat); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done k=%0d got=%b exp=0", k, done); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL loop_busy k=%0d got=%b exp=1", k, busy); end
    end
  endtask

  task automatic test_start_stop();
    int bad = 0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b exp=0", busy); end
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL stop_valid got=%b exp=0", dac_valid); end
    checks++; if (dac_data !== IDLE_EXP) begin errors++; $display("FAIL stop_data got=%h exp=%h", dac_data, IDLE_EXP); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL stop_done got=%b exp=0", done); end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (busy !== 1'b0 || dac_valid !== 1'b0 || done !== 1'b0 || dac_data !== IDLE_EXP) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stop_stays_idle got=%0d bad cycles exp=0", bad); end
  endtask

  task automatic test_len_zero();
    int bad = 0;
    len = 11'd0; rate_div = 16'd0; loop_en = 1'b0;
    tick();
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      tick();
      if (busy !== 1'b0 || dac_valid !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL len_zero got=%0d active cycles exp=0", bad); end
  endtask

  task automatic test_full_depth();
    int n = 0;
    int dn = 0;
    int mism = 0;
    int done_at = -1;
    for (int i = 0; i < 1024; i++) wr(i, i * 5 + 1);
    len = 11'd1024; rate_div = 16'd0; loop_en = 1'b0;
    tick();
    pulse_start();
    for (int c = 0; c < 1100; c++) begin
      tick();
      if (done === 1'b1) begin
        dn++;
        done_at = n;
        if (dac_valid !== 1'b1) mism++;
      end
      if (dac_valid === 1'b1) begin
        if (dac_data !== code(n * 5 + 1)) mism++;
        n++;
      end
    end
    checks++; if (n !== 1024) begin errors++; $display("FAIL full_count got=%0d exp=1024", n); end
    checks++; if (mism !== 0) begin errors++; $display("FAIL full_data got=%0d mismatches exp=0", mism); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL full_done_count got=%0d exp=1", dn); end
    checks++; if (done_at !== 1023) begin errors++; $display("FAIL full_done_pos got=%0d exp=1023", done_at); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end got=%b exp=0", busy); end
    checks++; if (dac_data !== code(1023 * 5 + 1)) begin errors++; $display("FAIL full_hold got=%h exp=%h", dac_data, code(1023 * 5 + 1)); end
  endtask

  task automatic test_collision();
    int vals[4] = '{100, 200, 300, 400};
    int idx;
    int ev_val;
    logic ev;
    for (int i = 0; i < 4; i++) wr(i, vals[i]);
    len = 11'd4; rate_div = 16'd3; loop_en = 1'b1;
    tick();
    pulse_start();
    for (int k = 1; k <= 22; k++) begin
      tick();
      wr_en = 1'b0;
      ev = (k >= 2) && (((k - 2) % 4) == 0);
      if (ev) begin
        idx = (k - 2) / 4;
        ev_val = (idx % 4 == 1 && idx >= 4) ? 555 : vals[idx % 4];
        checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL coll_valid k=%0d got=%b exp=1", k, dac_valid); end
        checks++; if (dac_data !== code(ev_val)) begin errors++; $display("FAIL coll_data k=%0d got=%h exp=%h", k, dac_data, code(ev_val)); end
      end
      if (k == 4) begin
        wr_en = 1'b1; wr_addr = 10'd1; wr_data = 14'd555;
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_play();
    len = 11'd4; rate_div = 16'd0; loop_en = 1'b1;
    pulse_start();
    tick(); tick(); tick();
    checks++; if (dac_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got=%b exp=1", dac_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got=%b exp=0", busy); end
    checks++; if (dac_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", dac_valid); end
    checks++; if (dac_data !== IDLE_EXP) begin errors++; $display("FAIL arst_data got=%h exp=%h", dac_data, IDLE_EXP); end
    tick();
    rst = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_after got=%b exp=0", busy); end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; loop_en = 1'b0; len = '0; rate_div = '0;
    tick(); tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_oneshot();
    tick(); tick();
    test_loop();
    test_start_stop();
    test_len_zero();
    test_full_depth();
    test_collision();
    test_reset_in_play();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dac_playback.md
# dac_playback

Arbitrary-waveform DAC source for the uberClock SoC. A CPU/CSR write port loads 14-bit samples into an on-chip sample RAM. A small FSM plays them out at a programmable sample rate, one-shot or looping. The registered output feeds the existing DDR-output `dac` block's `data1`/`data2` inputs, in place of the ADC loopback path, so waveforms are generated rather than echoed.

## Interface
Parameters:
- `ADDR_W`, 10: sample RAM address width; depth = 2^ADDR_W.
- `DATA_W`, 14: sample width, matching the DAC bus.

Ports:
- `sys_clk` in 1: single clock for all logic.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: RAM write strobe.
- `wr_addr` in ADDR_W: RAM write address.
- `wr_data` in DATA_W: two's-complement sample to write.
- `start` in 1: single-cycle request to begin playback.
- `stop` in 1: single-cycle request to abort playback.
- `loop_en` in 1: 1 = wrap to address 0 after the last sample; 0 = one-shot.
- `len` in ADDR_W+1: number of samples to play, 1..2^ADDR_W.
- `rate_div` in 16: sample period is `rate_div`+1 cycles.
- `busy` out 1: high while in PLAY.
- `done` out 1: one-cycle pulse coinciding with the final `dac_valid` of a one-shot run.
- `dac_valid` out 1: one-cycle pulse when `dac_data` updates.
- `dac_data` out DATA_W: registered DAC sample.

## Operation
- FSM states are IDLE and PLAY. Reset state is IDLE.
- Reset values:
  - `busy`, `done`, `dac_valid` = 0.
  - `dac_data` = IDLE_CODE. IDLE_CODE is 14'h0000, or 14'h2000 with the Configuration macro.
- IDLE → PLAY:
  - Occurs on `start`=1 with `len`≠0.
  - `len` and `rate_div` are latched at this point. `loop_en` is sampled live at each wrap.
  - Read address and divider counter are cleared to 0.
  - `start` with `len`=0 is ignored: no `busy`, no `done`.
- PLAY:
  - The divider counter counts 0..`rate_div_q`, then returns to 0.
  - A RAM read of the current address is issued when the counter equals 0.
  - After the read of address `len_q`-1:
    - with `loop_en`=1, the address returns to 0;
    - otherwise no further reads are issued, and the FSM returns to IDLE once that sample is output.
- End of a one-shot run: `done` pulses with the last `dac_valid`. `busy` falls on the following cycle. `dac_data` holds the last sample until the next start, stop or reset.
- `stop` in PLAY: next cycle the FSM enters IDLE, `busy`=0, `dac_data`=IDLE_CODE, no `done`, and any in-flight read is discarded. `stop` in IDLE forces `dac_data`=IDLE_CODE.
- `start` and `stop` in the same cycle: `stop` wins.
- `start` while `busy`: ignored.
- Writes are accepted in any state. A write and a read to the same address in the same cycle: the read returns the old data (read-first).
- No arithmetic on samples beyond the optional MSB inversion. Addresses wrap modulo `len_q`, never modulo the RAM depth.

## Timing
- `start` sampled at edge E0:
  - E1: `busy`=1 and the read of address 0 is clocked.
  - E2: `dac_data`=mem[0] and `dac_valid`=1 for one cycle.
- Latency from `start` to first `dac_valid` is 2 cycles. It is constant and applies to every sample.
- Successive `dac_valid` pulses are exactly `rate_div`+1 cycles apart, including across the loop wrap (no bubble).
- With `rate_div`=0, `dac_valid` is continuously high and a new sample appears every cycle.
- `stop` at edge Es: `busy`=0, `dac_valid`=0 and `dac_data`=IDLE_CODE after Es.

## Configuration
- Macro: `DAC_PLAYBACK_OFFSET_BINARY_EN`.
- Defined: `dac_data` = sample with its MSB inverted, converting two's complement to the offset-binary code the AN9767 expects. IDLE_CODE = 14'h2000 (mid-scale).
- Undefined: `dac_data` = the stored two's-complement sample unchanged. IDLE_CODE = 14'h0000.

## Structure
- Shared package `dac_playback_pkg`:
  - FSM state enum (IDLE, PLAY);
  - IDLE_CODE constants for both macro settings;
  - the `rate_div` width localparam (16).
- Sub-module `dac_playback_ram`:
  - simple dual-port, one write port and one read port;
  - synchronous read with 1-cycle latency, read-first;
  - inferable as BRAM.
- The FSM, divider counter and output register live in the top module.

## Test plan
- Reset with playback active (assert `rst` during PLAY) → next cycle `busy`=0, `dac_valid`=0, `dac_data`=IDLE_CODE, asynchronously.
- Load mem[0..3]=100,200,300,400, `len`=4, `rate_div`=0, `loop_en`=0, pulse `start` → `dac_valid` on cycles +2..+5 with data 100,200,300,400; `done` on +5; `busy` low on +6; `dac_data` holds 400.
- Same RAM contents, `rate_div`=3, `loop_en`=1 → output sequence 100,200,300,400,100,… with `dac_valid` every 4 cycles, no gap at the wrap, `done` never asserted.
- While looping, pulse `start` and `stop` in the same cycle → `stop` wins: IDLE next cycle, `dac_data`=IDLE_CODE, no `done`.
- `len`=0 with `start` → `busy` stays 0, no `dac_valid`. Then `len`=1024 (full depth) → 1024 samples, then `done`.
- Write mem[1]=555 in the same cycle as the read of address 1 → old value output this pass, 555 on the next loop. Repeat the run with `DAC_PLAYBACK_OFFSET_BINARY_EN` defined → sample 100 appears as 14'h2064 and idle reads 14'h2000.
